// File: rtl/milano_regfile.sv
// milano_regfile: 32-entry integer register file for the milano core.
// ALU and LSU write ports commit on the rising edge. Two combinational read ports
// can optionally forward same-cycle write data. x0 has no storage and always reads 0.
module milano_regfile #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter bit          BYPASS_EN  = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
    output logic [DATA_WIDTH-1:0] rs1_rdata_o,
    input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
    output logic [DATA_WIDTH-1:0] rs2_rdata_o,
    input  logic                  alu_we_i,
    input  logic [ADDR_WIDTH-1:0] alu_waddr_i,
    input  logic [DATA_WIDTH-1:0] alu_wdata_i,
    input  logic                  lsu_we_i,
    input  logic [ADDR_WIDTH-1:0] lsu_waddr_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    output logic                  wr_conflict_o
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

    // x1..x(NUM_REGS-1) only; x0 is never stored
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS-1:1];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS-1:1];
    logic                  conflict_q;
    logic                  conflict_d;

    // Effective write strobes: writes to x0 are discarded at the source
    logic alu_wr;
    logic lsu_wr;
    assign alu_wr = alu_we_i && (alu_waddr_i != '0);
    assign lsu_wr = lsu_we_i && (lsu_waddr_i != '0);

    // Next-state per register: ALU takes priority over LSU on the same index
    always_comb begin
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (alu_wr && (alu_waddr_i == ADDR_WIDTH'(i))) begin
                regs_d[i] = alu_wdata_i;
            end else if (lsu_wr && (lsu_waddr_i == ADDR_WIDTH'(i))) begin
                regs_d[i] = lsu_wdata_i;
            end
        end
    end

    // Register storage with asynchronous clear
    for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
        // Storage flop for one architectural register
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                regs_q[g] <= '0;
            end else begin
                regs_q[g] <= regs_d[g];
            end
        end
    end

    // Both ports hitting the same non-zero register: LSU data is dropped
    assign conflict_d = alu_wr && lsu_wr && (alu_waddr_i == lsu_waddr_i);

    // One-cycle conflict flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign wr_conflict_o = conflict_q;

    // Read port 1: x0, then ALU bypass, then LSU bypass, then storage
    always_comb begin
        rs1_rdata_o = '0;
        if (!rst_ni || (rs1_addr_i == '0)) begin
            rs1_rdata_o = '0;
        end else if (BYPASS_EN && alu_we_i && (alu_waddr_i == rs1_addr_i)) begin
            rs1_rdata_o = alu_wdata_i;
        end else if (BYPASS_EN && lsu_we_i && (lsu_waddr_i == rs1_addr_i)) begin
            rs1_rdata_o = lsu_wdata_i;
        end else begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (rs1_addr_i == ADDR_WIDTH'(i)) begin
                    rs1_rdata_o = regs_q[i];
                end
            end
        end
    end

    // Read port 2: same priority as port 1
    always_comb begin
        rs2_rdata_o = '0;
        if (!rst_ni || (rs2_addr_i == '0)) begin
            rs2_rdata_o = '0;
        end else if (BYPASS_EN && alu_we_i && (alu_waddr_i == rs2_addr_i)) begin
            rs2_rdata_o = alu_wdata_i;
        end else if (BYPASS_EN && lsu_we_i && (lsu_waddr_i == rs2_addr_i)) begin
            rs2_rdata_o = lsu_wdata_i;
        end else begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (rs2_addr_i == ADDR_WIDTH'(i)) begin
                    rs2_rdata_o = regs_q[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_milano_regfile.sv
// Self-checking bench for milano_regfile: one bypassing and one non-bypassing
// instance share all inputs and are compared against an architectural register model.
module tb_milano_regfile;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        alu_we, lsu_we;
    logic [4:0]  alu_waddr, lsu_waddr;
    logic [31:0] alu_wdata, lsu_wdata;
    logic [31:0] by_rs1, by_rs2, nb_rs1, nb_rs2;
    logic        by_conf, nb_conf;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] model [32];
    logic [31:0] nxt [32];
    logic        exp_conf;

    milano_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS_EN(1'b1)) u_by (
        .clk_i(clk), .rst_ni(rst_n),
        .rs1_addr_i(rs1_addr), .rs1_rdata_o(by_rs1),
        .rs2_addr_i(rs2_addr), .rs2_rdata_o(by_rs2),
        .alu_we_i(alu_we), .alu_waddr_i(alu_waddr), .alu_wdata_i(alu_wdata),
        .lsu_we_i(lsu_we), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
        .wr_conflict_o(by_conf)
    );

    milano_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS_EN(1'b0)) u_nb (
        .clk_i(clk), .rst_ni(rst_n),
        .rs1_addr_i(rs1_addr), .rs1_rdata_o(nb_rs1),
        .rs2_addr_i(rs2_addr), .rs2_rdata_o(nb_rs2),
        .alu_we_i(alu_we), .alu_waddr_i(alu_waddr), .alu_wdata_i(alu_wdata),
        .lsu_we_i(lsu_we), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
        .wr_conflict_o(nb_conf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Architectural effect of the current write requests: x0 fixed, ALU beats LSU
    task automatic compute_next();
        for (int i = 0; i < 32; i++) nxt[i] = model[i];
        if (lsu_we) nxt[lsu_waddr] = lsu_wdata;
        if (alu_we) nxt[alu_waddr] = alu_wdata;
        nxt[0] = 32'h0;
        exp_conf = alu_we && lsu_we && (alu_waddr == lsu_waddr) && (alu_waddr != 5'd0);
    endtask

    task automatic drive(input logic aw, input logic [4:0] awa, input logic [31:0] awd,
                         input logic lw, input logic [4:0] lwa, input logic [31:0] lwd,
                         input logic [4:0] r1, input logic [4:0] r2);
        alu_we = aw; alu_waddr = awa; alu_wdata = awd;
        lsu_we = lw; lsu_waddr = lwa; lsu_wdata = lwd;
        rs1_addr = r1; rs2_addr = r2;
    endtask

    // One clock: check reads before the edge, commit, then check the conflict flag
    task automatic cycle();
        compute_next();
        #2;
        // With bypass a read shows what the register will hold after this edge
        check("by_rs1", by_rs1, nxt[rs1_addr]);
        check("by_rs2", by_rs2, nxt[rs2_addr]);
        // Without bypass a read shows the currently held value
        check("nb_rs1", nb_rs1, model[rs1_addr]);
        check("nb_rs2", nb_rs2, model[rs2_addr]);
        @(posedge clk);
        for (int i = 0; i < 32; i++) model[i] = nxt[i];
        #1;
        check("by_conflict", 32'(by_conf), 32'(exp_conf));
        check("nb_conflict", 32'(nb_conf), 32'(exp_conf));
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, r1, r2);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        rst_n = 1'b0;
        drive(1'b1, 5'd1, 32'hFFFF_FFFF, 1'b1, 5'd2, 32'hEEEE_EEEE, 5'd0, 5'd0);

        // Reset: every register reads 0 on both ports, writes ignored
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
            alu_waddr = 5'(i); lsu_waddr = 5'(31 - i);
            #1;
            check("rst_rs1", by_rs1, 32'h0);
            check("rst_rs2", by_rs2, 32'h0);
        end
        check("rst_conflict", 32'(by_conf), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(5'd1, 5'd2);
        cycle();

        // ALU write x5, read back; x0 write discarded
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
        cycle();
        idle(5'd5, 5'd5);
        cycle();
        drive(1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
        cycle();
        idle(5'd0, 5'd0);
        cycle();

        // Dual write to different registers, bypass then storage
        drive(1'b1, 5'd7, 32'h11, 1'b1, 5'd9, 32'h22, 5'd7, 5'd9);
        cycle();
        idle(5'd7, 5'd9);
        cycle();

        // Same-index write: ALU wins, conflict flag for one cycle
        drive(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd3, 32'h5555, 5'd3, 5'd3);
        cycle();
        idle(5'd3, 5'd3);
        cycle();
        check("x3_alu_wins", by_rs1, 32'hAAAA);

        // Same-index write to x0: no conflict
        drive(1'b1, 5'd0, 32'h1, 1'b1, 5'd0, 32'h2, 5'd0, 5'd3);
        cycle();

        // x4: old value same cycle on the non-bypass copy, new value next cycle
        drive(1'b1, 5'd4, 32'h99, 1'b0, 5'd0, 32'h0, 5'd4, 5'd4);
        cycle();
        idle(5'd4, 5'd4);
        cycle();
        check("nb_x4_after", nb_rs1, 32'h99);

        // Randomized traffic, addresses often confined to force collisions
        for (int n = 0; n < 400; n++) begin
            logic [4:0] a1, a2;
            bit narrow;
            narrow = ($urandom_range(0, 3) == 0);
            a1 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            a2 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            drive(1'($urandom), a1, $urandom, 1'($urandom), a2, $urandom,
                  narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)));
            cycle();
        end

        // Fill x1..x31, end with a conflict so the flag is high going into reset
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 5'(i), $urandom | 32'h1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(32 - i));
            cycle();
        end
        drive(1'b1, 5'd6, 32'h6666, 1'b1, 5'd6, 32'h7777, 5'd6, 5'd6);
        cycle();
        check("pre_rst_conflict", 32'(by_conf), 32'h1);

        // Reset mid-write: everything reads 0 immediately
        drive(1'b1, 5'd8, 32'h8888, 1'b1, 5'd10, 32'hA0A0, 5'd8, 5'd10);
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        #1;
        check("midrst_conflict", 32'(by_conf), 32'h0);
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i); rs2_addr = 5'(i);
            alu_waddr = 5'(i);
            #1;
            check("midrst_rs1", by_rs1, 32'h0);
            check("midrst_rs2", nb_rs2, 32'h0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(5'd8, 5'd10);
        cycle();
        idle(5'd31, 5'd1);
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
